// File: rtl/fs_dither_stream.sv
// Streaming Floyd-Steinberg error-diffusion quantiser for a raster pixel stream.
// One pixel per cycle, single registered output stage with ready/valid handshakes.
module fs_dither_stream #(
    parameter int IMAGEX     = 16,
    parameter int IMAGEY     = 16,
    parameter int RGB_SIZE   = 8,
    parameter int QUANT_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [RGB_SIZE-1:0] in_data,
    output logic                in_ready,
    input  logic                dither_en,
    output logic                out_valid,
    output logic [RGB_SIZE-1:0] out_data,
    input  logic                out_ready,
    output logic                out_sof,
    output logic                out_eol,
    output logic                frame_done
);
    localparam int XW  = (IMAGEX > 2) ? $clog2(IMAGEX) : 1;
    localparam int YW  = (IMAGEY > 2) ? $clog2(IMAGEY) : 1;
    localparam int VW  = RGB_SIZE + 3;
    localparam int EW  = RGB_SIZE + 2;
    localparam int PW  = RGB_SIZE + 7;
    localparam int REP = (RGB_SIZE + QUANT_BITS - 1) / QUANT_BITS;
    localparam logic [XW-1:0]        X_LAST = XW'(IMAGEX - 1);
    localparam logic [YW-1:0]        Y_LAST = YW'(IMAGEY - 1);
    localparam logic signed [VW-1:0] V_MAX  = VW'((1 << RGB_SIZE) - 1);

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 den_frame;
    logic                 out_last;
    logic signed [EW-1:0] east;
    logic signed [EW-1:0] p0;
    logic signed [EW-1:0] p1;
    logic signed [EW-1:0] row_buf [IMAGEX];

    logic                      accept, first, last_x, last_y, den;
    logic signed [EW-1:0]      east_in, row_in, p1_in;
    logic signed [VW-1:0]      v, err;
    logic [RGB_SIZE-1:0]       vc, q;
    logic [QUANT_BITS-1:0]     idx;
    logic [REP*QUANT_BITS-1:0] rep;
    logic signed [PW-1:0]      errx, m7, m5, m3;
    logic signed [EW-1:0]      e7, e5, e3, e1;

    assign in_ready   = reset | ~out_valid | out_ready;
    assign accept     = in_valid & in_ready & ~reset;
    assign frame_done = out_valid & out_ready & out_last & ~reset;
    assign first      = (x == '0) && (y == '0);
    assign last_x     = (x == X_LAST);
    assign last_y     = (y == Y_LAST);
    // Pixel (0,0) uses the live enable; the rest of the frame uses the latched copy.
    assign den        = first ? dither_en : den_frame;

    always_comb begin
        east_in = (den && x != '0) ? east : '0;
        row_in  = (den && y != '0) ? row_buf[x] : '0;
        p1_in   = (x == '0) ? '0 : p1;
        v = {3'b000, in_data}
            + {{(VW-EW){east_in[EW-1]}}, east_in}
            + {{(VW-EW){row_in[EW-1]}}, row_in};
        if (v[VW-1]) begin
            vc = '0;
        end else if (v > V_MAX) begin
            vc = '1;
        end else begin
            vc = v[RGB_SIZE-1:0];
        end
        idx  = vc[RGB_SIZE-1 -: QUANT_BITS];
        rep  = {REP{idx}};
        q    = rep[REP*QUANT_BITS-1 -: RGB_SIZE];
        err  = {3'b000, vc} - {3'b000, q};
        errx = {{(PW-VW){err[VW-1]}}, err};
        m7   = (errx <<< 3) - errx;
        m5   = (errx <<< 2) + errx;
        m3   = (errx <<< 1) + errx;
        e7   = EW'(m7 >>> 4);
        e5   = EW'(m5 >>> 4);
        e3   = EW'(m3 >>> 4);
        e1   = EW'(errx >>> 4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_last  <= 1'b0;
            x         <= '0;
            y         <= '0;
            east      <= '0;
            den_frame <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= q;
            out_sof   <= first;
            out_eol   <= last_x;
            out_last  <= last_x & last_y;
            x         <= last_x ? '0 : x + XW'(1);
            if (last_x) y <= last_y ? '0 : y + YW'(1);
            if (first) den_frame <= dither_en;
            if (den) east <= last_x ? '0 : e7;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The buffer holds the current row until each column is read, so next-row
    // contributions are staged in p0 (column x-1) and p1 (column x) and a column
    // is only committed once its e3 share from the right neighbour is known.
    always_ff @(posedge clk) begin
        if (accept && den && !last_y) begin
            if (x != '0) row_buf[x - XW'(1)] <= p0 + e3;
            if (last_x) row_buf[x] <= p1_in + e5;
            p0 <= p1_in + e5;
            p1 <= e1;
        end
    end
endmodule
